// File: rtl/spec_history_tracker.sv
// Per-index history table with speculative shift-in on lookup and
// youngest-first repair from an in-flight undo queue on a mispredict.
module spec_history_tracker #(
  parameter int IWIDTH = 6,
  parameter int HWIDTH = 4,
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     en,
  input  logic                     lookup_valid,
  output logic                     lookup_ready,
  input  logic [IWIDTH-1:0]        lookup_index,
  input  logic                     lookup_pred,
  output logic [HWIDTH-1:0]        hist_out,
  input  logic                     resolve_valid,
  output logic                     resolve_ready,
  input  logic                     resolve_taken,
  output logic                     busy,
  output logic [$clog2(QDEPTH):0]  inflight
);

  // state    | meaning
  // S_IDLE   | accepting lookups and resolutions
  // S_REPAIR | unwinding the undo queue, one entry per enabled cycle

  localparam int QW   = $clog2(QDEPTH);
  localparam int CW   = QW + 1;
  localparam int NENT = 2 ** IWIDTH;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_REPAIR = 1'b1} state_t;

  state_t            state;
  logic [HWIDTH-1:0] tb_mem [NENT];
  logic [IWIDTH-1:0] q_idx  [QDEPTH];
  logic [HWIDTH-1:0] q_old  [QDEPTH];
  logic              q_pred [QDEPTH];
  logic [QW-1:0]     head;
  logic [QW-1:0]     tail;
  logic [QW-1:0]     r_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     rcnt;
  logic              taken_lat;

  logic idle;
  logic res_fire;
  logic mis_fire;
  logic look_fire;

  assign idle          = (state == S_IDLE);
  assign resolve_ready = en & idle & (count != '0);
  assign res_fire      = resolve_valid & resolve_ready;
  assign mis_fire      = res_fire & (resolve_taken != q_pred[head]);
  assign lookup_ready  = en & idle & (count < QFULL) & ~mis_fire;
  assign look_fire     = lookup_valid & lookup_ready;

  assign hist_out = tb_mem[lookup_index];
  assign busy     = (state == S_REPAIR);
  assign inflight = count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      head      <= '0;
      tail      <= '0;
      r_ptr     <= '0;
      count     <= '0;
      rcnt      <= '0;
      taken_lat <= 1'b0;
      for (int i = 0; i < NENT; i++) tb_mem[i] <= '0;
      for (int j = 0; j < QDEPTH; j++) begin
        q_idx[j]  <= '0;
        q_old[j]  <= '0;
        q_pred[j] <= 1'b0;
      end
    end else if (en) begin
      case (state)
        S_IDLE: begin
          if (mis_fire) begin
            // Head stays queued; it is rewritten last with the actual outcome.
            state     <= S_REPAIR;
            r_ptr     <= tail - 1'b1;
            rcnt      <= count - 1'b1;
            taken_lat <= resolve_taken;
          end else begin
            if (look_fire) begin
              q_idx[tail]  <= lookup_index;
              q_old[tail]  <= tb_mem[lookup_index];
              q_pred[tail] <= lookup_pred;
              tb_mem[lookup_index] <= {tb_mem[lookup_index][HWIDTH-2:0], lookup_pred};
              tail <= tail + 1'b1;
            end
            if (res_fire) head <= head + 1'b1;
            count <= count + CW'(look_fire) - CW'(res_fire);
          end
        end
        S_REPAIR: begin
          if (rcnt != '0) begin
            tb_mem[q_idx[r_ptr]] <= q_old[r_ptr];
            r_ptr <= r_ptr - 1'b1;
            rcnt  <= rcnt - 1'b1;
          end else begin
            tb_mem[q_idx[head]] <= {q_old[head][HWIDTH-2:0], taken_lat};
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spec_history_tracker.sv
// Bench for spec_history_tracker: directed vector table, repair sequences,
// and randomized traffic against a queue-based reference model.
`timescale 1ns/100ps
module tb_spec_history_tracker;
  localparam int IW = 6;
  localparam int HW = 4;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          en;
  logic          lookup_valid;
  logic          lookup_ready;
  logic [IW-1:0] lookup_index;
  logic          lookup_pred;
  logic [HW-1:0] hist_out;
  logic          resolve_valid;
  logic          resolve_ready;
  logic          resolve_taken;
  logic          busy;
  logic [2:0]    inflight;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spec_history_tracker #(.IWIDTH(IW), .HWIDTH(HW), .QDEPTH(QD)) dut (
    .clk(clk), .resetn(resetn), .en(en),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_index(lookup_index), .lookup_pred(lookup_pred),
    .hist_out(hist_out),
    .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
    .resolve_taken(resolve_taken),
    .busy(busy), .inflight(inflight)
  );

  typedef struct {
    logic          en, lv;
    logic [IW-1:0] idx;
    logic          pred, rv, taken;
    logic [HW-1:0] hist;
    logic          lr, rr, bz;
    logic [2:0]    infl;
  } vec_t;

  typedef struct { logic [IW-1:0] idx; logic [HW-1:0] old; logic pred; } ent_t;
  typedef struct { logic [IW-1:0] idx; logic [HW-1:0] val; } act_t;

  logic [HW-1:0] mtb [64];
  ent_t mq[$];
  act_t pend[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic e, input logic lv, input logic [IW-1:0] idx,
                        input logic p, input logic rv, input logic t);
    en = e; lookup_valid = lv; lookup_index = idx; lookup_pred = p;
    resolve_valid = rv; resolve_taken = t;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [IW-1:0] idx, output logic [HW-1:0] h);
    lookup_valid = 1'b0;
    lookup_index = idx;
    #0.1;
    h = hist_out;
  endtask

  task automatic scan_zero(input string name);
    int nz;
    logic [HW-1:0] h;
    nz = 0;
    for (int i = 0; i < 64; i++) begin
      rd(6'(i), h);
      if (h !== 4'b0000) nz++;
    end
    check(name, 32'(nz), 32'd0);
    tick;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".inflight"}, 32'(inflight), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".resolve_ready"}, 32'(resolve_ready), 32'd0);
    check({tag, ".lookup_ready"}, 32'(lookup_ready), 32'd1);
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    set_in(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    tick;
    resetn = 1'b1;
    tick;
  endtask

  task automatic case5_setup;
    set_in(1'b1, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0); tick;
    set_in(1'b1, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0); tick;
    set_in(1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0); tick;
    set_in(1'b1, 1'b1, 6'd3, 1'b0, 1'b1, 1'b0);
    check("c5.mis_resolve_ready", 32'(resolve_ready), 32'd1);
    check("c5.mis_lookup_ready", 32'(lookup_ready), 32'd0);
    tick;
    set_in(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic count_busy(input int pa, input int pl, output int n);
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      set_in((n >= pa && n < pa + pl) ? 1'b0 : 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
      n++;
      tick;
    end
  endtask

  task automatic case5_run(input string tag, input int pa, input int pl, input int exp_n);
    int n;
    logic [HW-1:0] h;
    do_reset();
    case5_setup();
    count_busy(pa, pl, n);
    check({tag, ".busy_cycles"}, 32'(n), 32'(exp_n));
    rd(6'd3, h);
    check({tag, ".tb3"}, 32'(h), 32'd0);
    rd(6'd7, h);
    check({tag, ".tb7"}, 32'(h), 32'd0);
    check({tag, ".inflight"}, 32'(inflight), 32'd0);
    tick;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 64; i++) mtb[i] = '0;
    mq.delete();
    pend.delete();
  endtask

  task automatic rand_phase(input int ncyc);
    logic e, lv, p, rv, t, exp_rr, exp_lr, mis, lfire, rfire;
    logic [IW-1:0] idx;
    act_t a;
    for (int c = 0; c < ncyc; c++) begin
      e   = ($urandom_range(0, 9) != 0);
      lv  = ($urandom_range(0, 9) < 6);
      idx = 6'($urandom_range(0, 7));
      p   = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 9) < 4);
      if (mq.size() > 0) t = mq[0].pred ^ ($urandom_range(0, 5) == 0);
      else               t = 1'($urandom_range(0, 1));
      set_in(e, lv, idx, p, rv, t);

      exp_rr = e && pend.size() == 0 && mq.size() > 0;
      mis    = rv && exp_rr && (t != mq[0].pred);
      exp_lr = e && pend.size() == 0 && mq.size() < QD && !mis;
      lfire  = lv && exp_lr;
      rfire  = rv && exp_rr;
      check("rnd.lookup_ready", 32'(lookup_ready), 32'(exp_lr));
      check("rnd.resolve_ready", 32'(resolve_ready), 32'(exp_rr));
      check("rnd.busy", 32'(busy), 32'(pend.size() != 0));
      check("rnd.inflight", 32'(inflight), 32'(mq.size()));
      check("rnd.hist_out", 32'(hist_out), 32'(mtb[idx]));

      if (e) begin
        if (pend.size() > 0) begin
          a = pend.pop_front();
          mtb[a.idx] = a.val;
          if (pend.size() == 0) mq.delete();
        end else if (mis) begin
          for (int i = mq.size() - 1; i >= 1; i--) pend.push_back('{mq[i].idx, mq[i].old});
          pend.push_back('{mq[0].idx, {mq[0].old[HW-2:0], t}});
        end else begin
          if (rfire) void'(mq.pop_front());
          if (lfire) begin
            mq.push_back('{idx, mtb[idx], p});
            mtb[idx] = {mtb[idx][HW-2:0], p};
          end
        end
      end
      tick;
    end
  endtask

  vec_t vt[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    set_in(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    tick;
    check_reset_outputs("reset0");
    scan_zero("reset0.tb_zero");
    resetn = 1'b1;
    tick;

    // en lv idx pred rv taken | hist lr rr busy inflight
    vt.push_back('{1'b1,1'b1,6'd5,1'b1,1'b0,1'b0, 4'b0000,1'b1,1'b0,1'b0,3'd0});
    vt.push_back('{1'b1,1'b1,6'd5,1'b1,1'b0,1'b0, 4'b0001,1'b1,1'b1,1'b0,3'd1});
    vt.push_back('{1'b1,1'b1,6'd5,1'b1,1'b0,1'b0, 4'b0011,1'b1,1'b1,1'b0,3'd2});
    vt.push_back('{1'b1,1'b0,6'd5,1'b0,1'b0,1'b0, 4'b0111,1'b1,1'b1,1'b0,3'd3});
    vt.push_back('{1'b1,1'b0,6'd5,1'b0,1'b1,1'b1, 4'b0111,1'b1,1'b1,1'b0,3'd3});
    vt.push_back('{1'b1,1'b0,6'd5,1'b0,1'b1,1'b1, 4'b0111,1'b1,1'b1,1'b0,3'd2});
    vt.push_back('{1'b1,1'b0,6'd5,1'b0,1'b1,1'b1, 4'b0111,1'b1,1'b1,1'b0,3'd1});
    vt.push_back('{1'b1,1'b0,6'd5,1'b0,1'b0,1'b0, 4'b0111,1'b1,1'b0,1'b0,3'd0});
    vt.push_back('{1'b1,1'b0,6'd5,1'b0,1'b1,1'b1, 4'b0111,1'b1,1'b0,1'b0,3'd0});
    vt.push_back('{1'b1,1'b1,6'd9,1'b0,1'b0,1'b0, 4'b0000,1'b1,1'b0,1'b0,3'd0});
    vt.push_back('{1'b1,1'b1,6'd9,1'b0,1'b0,1'b0, 4'b0000,1'b1,1'b1,1'b0,3'd1});
    vt.push_back('{1'b1,1'b1,6'd9,1'b0,1'b0,1'b0, 4'b0000,1'b1,1'b1,1'b0,3'd2});
    vt.push_back('{1'b1,1'b1,6'd9,1'b0,1'b0,1'b0, 4'b0000,1'b1,1'b1,1'b0,3'd3});
    vt.push_back('{1'b1,1'b1,6'd9,1'b0,1'b1,1'b0, 4'b0000,1'b0,1'b1,1'b0,3'd4});
    vt.push_back('{1'b0,1'b1,6'd9,1'b0,1'b1,1'b0, 4'b0000,1'b0,1'b0,1'b0,3'd3});
    vt.push_back('{1'b1,1'b0,6'd9,1'b0,1'b0,1'b0, 4'b0000,1'b1,1'b1,1'b0,3'd3});
    vt.push_back('{1'b1,1'b0,6'd9,1'b0,1'b1,1'b0, 4'b0000,1'b1,1'b1,1'b0,3'd3});
    vt.push_back('{1'b1,1'b0,6'd9,1'b0,1'b1,1'b0, 4'b0000,1'b1,1'b1,1'b0,3'd2});
    vt.push_back('{1'b1,1'b0,6'd9,1'b0,1'b1,1'b0, 4'b0000,1'b1,1'b1,1'b0,3'd1});
    vt.push_back('{1'b1,1'b0,6'd9,1'b0,1'b0,1'b0, 4'b0000,1'b1,1'b0,1'b0,3'd0});

    for (int i = 0; i < vt.size(); i++) begin
      set_in(vt[i].en, vt[i].lv, vt[i].idx, vt[i].pred, vt[i].rv, vt[i].taken);
      check($sformatf("vec%0d.hist_out", i), 32'(hist_out), 32'(vt[i].hist));
      check($sformatf("vec%0d.lookup_ready", i), 32'(lookup_ready), 32'(vt[i].lr));
      check($sformatf("vec%0d.resolve_ready", i), 32'(resolve_ready), 32'(vt[i].rr));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vt[i].bz));
      check($sformatf("vec%0d.inflight", i), 32'(inflight), 32'(vt[i].infl));
      tick;
    end

    case5_run("c5", 100, 0, 3);
    case5_run("c6", 1, 2, 5);

    do_reset();
    case5_setup();
    tick;
    check("c6r.busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("c6r");
    scan_zero("c6r.tb_zero");
    resetn = 1'b1;
    tick;

    do_reset();
    model_reset();
    rand_phase(600);

    resetn = 1'b0;
    set_in(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    check_reset_outputs("reset1");
    scan_zero("reset1.tb_zero");
    resetn = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
